// File: rtl/wb_commit_pkg.sv
// Shared widths, constants and the write-beat type for the write-back commit slice.
// Optional feature macro used by this slice: WB_COMMIT_BYPASS_EN.
package wb_commit_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_NUM    = 32;

   localparam logic                  RST_ENABLE    = 1'b1;
   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;
   localparam logic                  READ_ENABLE   = 1'b1;
   localparam logic [REG_W-1:0]      ZERO_WORD     = 32'h0000_0000;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'd0;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_W-1:0]      data;
   } gpr_wr_t;

   // A WB write to a nonzero register that the read port is currently asking for.
   function automatic logic bypass_hit(input logic re, input gpr_wr_t wr,
                                       input logic [REG_ADDR_W-1:0] raddr);
      return (re == READ_ENABLE) && (wr.we == WRITE_ENABLE) &&
             (wr.addr == raddr) && (raddr != NOP_REG_ADDR);
   endfunction

endpackage

// File: rtl/wb_gpr_array.sv
// 32 x 32 general-purpose register file with two combinational read ports.
// WB_COMMIT_BYPASS_EN forwards the same-cycle WB write data to the read ports.
module wb_gpr_array
   import wb_commit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  gpr_wr_t               wr,
   input  logic                  re1,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic                  re2,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [REG_W-1:0]      rdata1,
   output logic [REG_W-1:0]      rdata2
);

   logic [REG_W-1:0] gpr_q [REG_NUM];
   logic [REG_W-1:0] gpr_d [REG_NUM];

   function automatic logic [REG_W-1:0] read_port(input logic rst_i, input logic re,
                                                 input logic [REG_ADDR_W-1:0] raddr,
                                                 input gpr_wr_t wr_i,
                                                 input logic [REG_W-1:0] stored);
      logic [REG_W-1:0] value;
      if (rst_i == RST_ENABLE || re != READ_ENABLE || raddr == NOP_REG_ADDR) begin
         value = ZERO_WORD;
      end else begin
`ifdef WB_COMMIT_BYPASS_EN
         value = bypass_hit(re, wr_i, raddr) ? wr_i.data : stored;
`else
         value = stored;
`endif
      end
      return value;
   endfunction

   always_comb begin
      gpr_d = gpr_q;
      // $0 is never stored; reset discards any write presented alongside it.
      if (rst != RST_ENABLE && wr.we == WRITE_ENABLE && wr.addr != NOP_REG_ADDR) begin
         gpr_d[wr.addr] = wr.data;
      end else begin
         gpr_d = gpr_q;
      end
   end

   always_ff @(posedge clk) begin
      gpr_q <= gpr_d;
   end

   always_comb begin
      rdata1 = read_port(rst, re1, raddr1, wr, gpr_q[raddr1]);
      rdata2 = read_port(rst, re2, raddr2, wr, gpr_q[raddr2]);
   end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit: GPR file (sub-module), architectural HI/LO and the LL/SC LLbit.
// Macro WB_COMMIT_BYPASS_EN enables write-through forwarding on the GPR read ports.
module wb_commit
   import wb_commit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] wb_wd,
   input  logic                  wb_wreg,
   input  logic [REG_W-1:0]      wb_wdata,
   input  logic [REG_W-1:0]      wb_hi,
   input  logic [REG_W-1:0]      wb_lo,
   input  logic                  wb_whilo,
   input  logic                  wb_LLbit_we,
   input  logic                  wb_LLbit_value,
   input  logic                  flush,
   input  logic                  re1,
   input  logic                  re2,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [REG_W-1:0]      rdata1,
   output logic [REG_W-1:0]      rdata2,
   output logic [REG_W-1:0]      hi_o,
   output logic [REG_W-1:0]      lo_o,
   output logic                  LLbit_o
);

   gpr_wr_t          gpr_wr;
   logic [REG_W-1:0] hi_d, hi_q, lo_d, lo_q;
   logic             llbit_d, llbit_q;

   assign gpr_wr = '{we: wb_wreg, addr: wb_wd, data: wb_wdata};

   wb_gpr_array u_gpr (
      .clk    (clk),
      .rst    (rst),
      .wr     (gpr_wr),
      .re1    (re1),
      .raddr1 (raddr1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   // Flush kills only the link bit; HI/LO of the instruction already in WB still commit.
   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      llbit_d = llbit_q;
      if (rst == RST_ENABLE) begin
         hi_d    = ZERO_WORD;
         lo_d    = ZERO_WORD;
         llbit_d = 1'b0;
      end else begin
         if (wb_whilo == WRITE_ENABLE) begin
            hi_d = wb_hi;
            lo_d = wb_lo;
         end else begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
         if (flush) begin
            llbit_d = 1'b0;
         end else if (wb_LLbit_we == WRITE_ENABLE) begin
            llbit_d = wb_LLbit_value;
         end else begin
            llbit_d = llbit_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llbit_q <= llbit_d;
   end

   always_comb begin
      hi_o = hi_q;
      lo_o = lo_q;
      if (rst == RST_ENABLE || flush) begin
         LLbit_o = 1'b0;
      end else if (wb_LLbit_we == WRITE_ENABLE) begin
         LLbit_o = wb_LLbit_value;
      end else begin
         LLbit_o = llbit_q;
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit; expectations follow WB_COMMIT_BYPASS_EN.
module tb_wb_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata, wb_hi, wb_lo;
   logic        wb_whilo, wb_LLbit_we, wb_LLbit_value, flush;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2, hi_o, lo_o;
   logic        LLbit_o;

   int n_tests = 0;
   int n_fail  = 0;

   wb_commit dut (
      .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
      .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
      .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wb_wd = 5'd0; wb_wreg = 1'b0; wb_wdata = 32'h0;
      wb_hi = 32'h0; wb_lo = 32'h0; wb_whilo = 1'b0;
      wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd0;

      // Reset held for two cycles.
      tick(); tick();
      #1;
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      chk("rst_llbit", {31'h0, LLbit_o}, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);

      // Write $3, read next cycle.
      rst = 1'b0; re1 = 1'b0;
      wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1234_5678;
      tick();
      wb_wreg = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
      #1 chk("rd_r3", rdata1, 32'h1234_5678);
      re1 = 1'b0;
      #1 chk("rd_disabled", rdata1, 32'h0);

      // Writes to $0 are ignored.
      wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF; re1 = 1'b1; raddr1 = 5'd0;
      #1 chk("rd_r0_same", rdata1, 32'h0);
      tick();
      wb_wreg = 1'b0;
      #1 chk("rd_r0_next", rdata1, 32'h0);

      // Same-cycle write/read of $7, with a known old value.
      wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h1111_1111;
      tick();
      wb_wdata = 32'hA5A5_A5A5; re2 = 1'b1; raddr2 = 5'd7;
`ifdef WB_COMMIT_BYPASS_EN
      #1 chk("bypass_r7", rdata2, 32'hA5A5_A5A5);
`else
      #1 chk("nobypass_r7", rdata2, 32'h1111_1111);
`endif
      re2 = 1'b0;
      #1 chk("bypass_re_off", rdata2, 32'h0);
      tick();
      wb_wreg = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
      #1 chk("r7_port1", rdata1, 32'hA5A5_A5A5);
      chk("r7_port2", rdata2, 32'hA5A5_A5A5);
      raddr1 = 5'd3;
      #1 chk("ports_indep", rdata1, 32'h1234_5678);

      // HI/LO write, then a disabled write.
      wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
      tick();
      chk("hi_wr", hi_o, 32'h1);
      chk("lo_wr", lo_o, 32'h2);
      wb_whilo = 1'b0; wb_hi = 32'h9; wb_lo = 32'h8;
      tick();
      chk("hi_hold", hi_o, 32'h1);
      chk("lo_hold", lo_o, 32'h2);

      // GPR and HI/LO written in the same cycle.
      wb_wreg = 1'b1; wb_wd = 5'd8; wb_wdata = 32'hDEAD_BEEF;
      wb_whilo = 1'b1; wb_hi = 32'h3; wb_lo = 32'h4;
      tick();
      wb_wreg = 1'b0; wb_whilo = 1'b0; raddr2 = 5'd8;
      #1 chk("dual_gpr", rdata2, 32'hDEAD_BEEF);
      chk("dual_hi", hi_o, 32'h3);
      chk("dual_lo", lo_o, 32'h4);

      // LLbit set: visible combinationally, then held by the register.
      wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
      #1 chk("ll_set_comb", {31'h0, LLbit_o}, 32'h1);
      tick();
      wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
      #1 chk("ll_held", {31'h0, LLbit_o}, 32'h1);

      // Flush beats LLbit write but still commits the GPR write.
      flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
      wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h0000_0055;
      #1 chk("ll_flush_comb", {31'h0, LLbit_o}, 32'h0);
      tick();
      flush = 1'b0; wb_LLbit_we = 1'b0; wb_wreg = 1'b0; raddr1 = 5'd4;
      #1 chk("ll_flush_reg", {31'h0, LLbit_o}, 32'h0);
      chk("flush_gpr_commit", rdata1, 32'h0000_0055);

      // Set LLbit again, then reset with a pending write to $4.
      wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
      tick();
      wb_LLbit_we = 1'b0;
      rst = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h0000_0066;
      #1 chk("rst_rdata_zero", rdata1, 32'h0);
      chk("rst_llbit_comb", {31'h0, LLbit_o}, 32'h0);
      tick();
      chk("rst_hi_clr", hi_o, 32'h0);
      chk("rst_lo_clr", lo_o, 32'h0);
      rst = 1'b0; wb_wreg = 1'b0;
      #1 chk("rst_write_drop", rdata1, 32'h0000_0055);
      chk("rst_llbit_clr", {31'h0, LLbit_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
